// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipelined control back-end.
// Stage bundles, ALUOp and forwarding encodings, opcodes.
package ctrl_pkg;

   typedef enum logic [1:0] {
      OTHER_OP = 2'b00,
      B_OP     = 2'b01,
      R_OP     = 2'b10
   } aluop_e;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   localparam logic [6:0] OPC_R    = 7'b0110011;
   localparam logic [6:0] OPC_I    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD = 7'b0000011;
   localparam logic [6:0] OPC_STOR = 7'b0100011;
   localparam logic [6:0] OPC_BR   = 7'b1100011;

   typedef struct packed {
      logic       regwrite;
      logic       memtoreg;
      logic       memread;
      logic       memwrite;
      logic [1:0] aluop;
      logic       alusrc;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } id_ex_t;

   typedef struct packed {
      logic       regwrite;
      logic       memtoreg;
      logic       memread;
      logic       memwrite;
      logic [4:0] rd;
   } ex_mem_t;

   typedef struct packed {
      logic       regwrite;
      logic       memtoreg;
      logic [4:0] rd;
   } mem_wb_t;

endpackage

// File: rtl/ctrl_stage_reg.sv
// Generic stage-bundle register with sync reset and bubble insert.
// Ports: clk_i, rst_i, bubble_i, d_i[W], q_o[W]; bubble = all zero.
module ctrl_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         bubble_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   always_comb begin
      data_d = d_i;
      if (bubble_i) data_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) data_q <= '0;
      else       data_q <= data_d;
   end

   assign q_o = data_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control back-end: ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, branch flush and EX forwarding selects.
// In: clk_i, rst_i, start_i, ID controls and rs1/rs2/rd indices.
// Out: EX/MEM/WB controls, ForwardA/B, PCWrite, IFIDWrite, Flush, Stall.
module ctrl_pipe
   import ctrl_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       Branch_i,
   input  logic       MemRead_i,
   input  logic       MemtoReg_i,
   input  logic       MemWrite_i,
   input  logic       ALUSrc_i,
   input  logic       RegWrite_i,
   input  logic [1:0] ALUOp_i,
   input  logic [4:0] RS1addr_i,
   input  logic [4:0] RS2addr_i,
   input  logic [4:0] RDaddr_i,
   output logic [1:0] EX_ALUOp_o,
   output logic       EX_ALUSrc_o,
   output logic [4:0] EX_RDaddr_o,
   output logic       MEM_MemRead_o,
   output logic       MEM_MemWrite_o,
   output logic       WB_MemtoReg_o,
   output logic       WB_RegWrite_o,
   output logic [4:0] WB_RDaddr_o,
   output logic [1:0] ForwardA_o,
   output logic [1:0] ForwardB_o,
   output logic       PCWrite_o,
   output logic       IFIDWrite_o,
   output logic       Flush_o,
   output logic       Stall_o
);

   id_ex_t  idex_d,  idex_q;
   ex_mem_t exmem_d, exmem_q;
   mem_wb_t memwb_d, memwb_q;

   logic stall;
   logic rd_hit;

   always_comb begin
      idex_d.regwrite = RegWrite_i;
      idex_d.memtoreg = MemtoReg_i;
      idex_d.memread  = MemRead_i;
      idex_d.memwrite = MemWrite_i;
      idex_d.aluop    = ALUOp_i;
      idex_d.alusrc   = ALUSrc_i;
      idex_d.rs1      = RS1addr_i;
      idex_d.rs2      = RS2addr_i;
      idex_d.rd       = RDaddr_i;
   end

   always_comb begin
      exmem_d.regwrite = idex_q.regwrite;
      exmem_d.memtoreg = idex_q.memtoreg;
      exmem_d.memread  = idex_q.memread;
      exmem_d.memwrite = idex_q.memwrite;
      exmem_d.rd       = idex_q.rd;
   end

   always_comb begin
      memwb_d.regwrite = exmem_q.regwrite;
      memwb_d.memtoreg = exmem_q.memtoreg;
      memwb_d.rd       = exmem_q.rd;
   end

   // A load in EX whose rd feeds the ID instruction must wait one
   // cycle; gated by start_i so a halted pipe never reports a stall.
   assign rd_hit = (idex_q.rd == RS1addr_i) ||
                   (idex_q.rd == RS2addr_i);
   assign stall  = start_i && idex_q.memread &&
                   (idex_q.rd != 5'd0) && rd_hit;

   assign Stall_o     = stall;
   assign PCWrite_o   = start_i && !stall;
   assign IFIDWrite_o = start_i && !stall;
   assign Flush_o     = start_i && Branch_i && !stall;

   ctrl_stage_reg #(.W($bits(id_ex_t))) u_idex (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .bubble_i (!start_i || stall),
      .d_i      (idex_d),
      .q_o      (idex_q)
   );

   ctrl_stage_reg #(.W($bits(ex_mem_t))) u_exmem (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .bubble_i (!start_i),
      .d_i      (exmem_d),
      .q_o      (exmem_q)
   );

   ctrl_stage_reg #(.W($bits(mem_wb_t))) u_memwb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .bubble_i (!start_i),
      .d_i      (memwb_d),
      .q_o      (memwb_q)
   );

   // EX/MEM is the younger producer, so it wins over MEM/WB.
   function automatic logic [1:0] fwd_sel(
      input ex_mem_t    m,
      input mem_wb_t    w,
      input logic [4:0] rs
   );
      logic [1:0] sel;
      sel = FWD_REG;
      if (m.regwrite && m.rd != 5'd0 && m.rd == rs)
         sel = FWD_EXMEM;
      else if (w.regwrite && w.rd != 5'd0 && w.rd == rs)
         sel = FWD_MEMWB;
      return sel;
   endfunction

   assign ForwardA_o = fwd_sel(exmem_q, memwb_q, idex_q.rs1);
   assign ForwardB_o = fwd_sel(exmem_q, memwb_q, idex_q.rs2);

   assign EX_ALUOp_o     = idex_q.aluop;
   assign EX_ALUSrc_o    = idex_q.alusrc;
   assign EX_RDaddr_o    = idex_q.rd;
   assign MEM_MemRead_o  = exmem_q.memread;
   assign MEM_MemWrite_o = exmem_q.memwrite;
   assign WB_MemtoReg_o  = memwb_q.memtoreg;
   assign WB_RegWrite_o  = memwb_q.regwrite;
   assign WB_RDaddr_o    = memwb_q.rd;

endmodule
